// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a triangle's clamped screen-tile bounding box in raster order and issues one tile request per tile.
package tile_scheduler_pkg;
  localparam int FX_INT_BITS   = 12;
  localparam int FX_FRAC_BITS  = 4;
  localparam int FX_TOTAL_BITS = FX_INT_BITS + FX_FRAC_BITS;
  localparam int TILE_SHIFT    = 5;
  localparam int NUM_TILE_COLS = 20;
  localparam int NUM_TILE_ROWS = 15;
  localparam int TX_W = $clog2(NUM_TILE_COLS);
  localparam int TY_W = $clog2(NUM_TILE_ROWS);
  typedef struct packed {
    logic signed [FX_TOTAL_BITS-1:0] x;
    logic signed [FX_TOTAL_BITS-1:0] y;
    logic signed [FX_TOTAL_BITS-1:0] z;
  } coord_3d_t;
  typedef struct packed {
    logic [TX_W-1:0] tile_x;
    logic [TY_W-1:0] tile_y;
    logic [3:0]      color;
  } metadata_t;
endpackage

module tile_scheduler
  import tile_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_vld,
  output logic        tri_rdy,
  input  coord_3d_t   tri_v0,
  input  coord_3d_t   tri_v1,
  input  coord_3d_t   tri_v2,
  input  logic [3:0]  tri_color,
  output logic        tile_vld,
  input  logic        tile_rdy,
  output coord_3d_t   tile_v0,
  output coord_3d_t   tile_v1,
  output coord_3d_t   tile_v2,
  output metadata_t   tile_meta,
  output logic        tri_done,
  output logic [15:0] tiles_issued
);
  localparam int SH = FX_FRAC_BITS + TILE_SHIFT;
  localparam int TW = FX_INT_BITS - TILE_SHIFT + 1;
  typedef logic signed [TW-1:0] tidx_t;
  typedef logic signed [FX_TOTAL_BITS-1:0] fx_t;
  localparam tidx_t LAST_X = TW'(NUM_TILE_COLS - 1);
  localparam tidx_t LAST_Y = TW'(NUM_TILE_ROWS - 1);
  typedef enum logic [2:0] {IDLE, BBOX, CLAMP, ISSUE, DONE} state_t;
  state_t          state_q, state_d;
  coord_3d_t       v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [3:0]      color_q, color_d;
  tidx_t           mnx_q, mnx_d, mny_q, mny_d, mxx_q, mxx_d, mxy_q, mxy_d;
  logic [TX_W-1:0] lox_q, lox_d, hix_q, hix_d, cx_q, cx_d;
  logic [TY_W-1:0] loy_q, loy_d, hiy_q, hiy_d, cy_q, cy_d;
  logic [15:0]     cnt_q, cnt_d;

  function automatic fx_t min3(input fx_t a, input fx_t b, input fx_t c);
    return (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
  endfunction

  function automatic fx_t max3(input fx_t a, input fx_t b, input fx_t c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction

  // Arithmetic shift keeps negative coords on negative tile indices so they cull/clamp correctly.
  function automatic tidx_t tile_of(input fx_t c);
    return tidx_t'(c >>> SH);
  endfunction

  always_comb begin
    state_d = state_q;
    v0_d = v0_q;
    v1_d = v1_q;
    v2_d = v2_q;
    color_d = color_q;
    mnx_d = mnx_q;
    mny_d = mny_q;
    mxx_d = mxx_q;
    mxy_d = mxy_q;
    lox_d = lox_q;
    loy_d = loy_q;
    hix_d = hix_q;
    hiy_d = hiy_q;
    cx_d = cx_q;
    cy_d = cy_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (tri_vld) begin
        v0_d = tri_v0;
        v1_d = tri_v1;
        v2_d = tri_v2;
        color_d = tri_color;
        cnt_d = '0;
        state_d = BBOX;
      end
      BBOX: begin
        mnx_d = tile_of(min3(v0_q.x, v1_q.x, v2_q.x));
        mny_d = tile_of(min3(v0_q.y, v1_q.y, v2_q.y));
        mxx_d = tile_of(max3(v0_q.x, v1_q.x, v2_q.x));
        mxy_d = tile_of(max3(v0_q.y, v1_q.y, v2_q.y));
        state_d = CLAMP;
      end
      CLAMP: if (mxx_q[TW-1] || mxy_q[TW-1] || mnx_q > LAST_X || mny_q > LAST_Y) begin
        state_d = DONE;
      end else begin
        lox_d = mnx_q[TW-1] ? '0 : mnx_q[TX_W-1:0];
        loy_d = mny_q[TW-1] ? '0 : mny_q[TY_W-1:0];
        hix_d = (mxx_q > LAST_X) ? TX_W'(NUM_TILE_COLS - 1) : mxx_q[TX_W-1:0];
        hiy_d = (mxy_q > LAST_Y) ? TY_W'(NUM_TILE_ROWS - 1) : mxy_q[TY_W-1:0];
        cx_d = lox_d;
        cy_d = loy_d;
        state_d = ISSUE;
      end
      ISSUE: if (tile_rdy) begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        if (cx_q < hix_q) begin
          cx_d = cx_q + TX_W'(1);
        end else if (cy_q < hiy_q) begin
          cx_d = lox_q;
          cy_d = cy_q + TY_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v0_q <= '0;
      v1_q <= '0;
      v2_q <= '0;
      color_q <= '0;
      mnx_q <= '0;
      mny_q <= '0;
      mxx_q <= '0;
      mxy_q <= '0;
      lox_q <= '0;
      loy_q <= '0;
      hix_q <= '0;
      hiy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      color_q <= color_d;
      mnx_q <= mnx_d;
      mny_q <= mny_d;
      mxx_q <= mxx_d;
      mxy_q <= mxy_d;
      lox_q <= lox_d;
      loy_q <= loy_d;
      hix_q <= hix_d;
      hiy_q <= hiy_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      cnt_q <= cnt_d;
    end
  end

  assign tri_rdy = state_q == IDLE;
  assign tile_vld = state_q == ISSUE;
  assign tri_done = state_q == DONE;
  assign tile_v0 = v0_q;
  assign tile_v1 = v1_q;
  assign tile_v2 = v2_q;
  assign tile_meta = '{tile_x: cx_q, tile_y: cy_q, color: color_q};
  assign tiles_issued = cnt_q;
endmodule
